// File: rtl/broadcast_responder_if.sv
// Handshake bundle for broadcast_responder: upstream req/ack/data toward the
// producing responder and per-consumer req/ack/data toward the requesters.
// slave  : view taken by broadcast_responder itself.
// master : view taken by the surrounding fabric (upstream node + consumers).
interface broadcast_responder_if #(
    parameter int data_width  = 32,
    parameter int output_size = 2
);
    logic                               req_l;
    logic                               ack_l;
    logic [data_width-1:0]              din;
    logic [output_size-1:0]             req_r;
    logic [output_size-1:0]             ack_r;
    logic [data_width*output_size-1:0]  dout;

    modport slave (
        output req_l,
        input  ack_l,
        input  din,
        input  req_r,
        output ack_r,
        output dout
    );

    modport master (
        input  req_l,
        output ack_l,
        output din,
        output req_r,
        input  ack_r,
        input  dout
    );
endinterface

// File: rtl/broadcast_responder.sv
// broadcast_responder: pulls words from one upstream responder into a small
// FIFO and replays every word, in order, to output_size independent
// consumers. One write pointer, one read pointer per consumer; a slot is
// reused only after the slowest consumer has read it.
// Optional feature macro: BROADCAST_RESPONDER_BYPASS_EN -- when defined, an
// accepted upstream word is handed straight to any empty, requesting
// consumer on the same edge it is written.
module broadcast_responder #(
    parameter int data_width  = 32,
    parameter int depth       = 4,
    parameter int output_size = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    broadcast_responder_if.slave    bus
);
    localparam int AW = $clog2(depth);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(depth);

    logic [data_width-1:0]              mem_q [depth];
    logic [PW-1:0]                      wp_q, wp_d;
    logic [PW-1:0]                      rp_q [output_size];
    logic [PW-1:0]                      rp_d [output_size];
    logic [output_size-1:0]             ack_r_q, ack_r_d;
    logic [data_width*output_size-1:0]  dout_q, dout_d;
    logic                               req_l_q, req_l_d;

    logic [PW-1:0]                      occ_s [output_size];
    logic [PW-1:0]                      fill_s;
    logic                               full_s;
    logic                               wr_en_s;

    assign bus.req_l = req_l_q;
    assign bus.ack_r = ack_r_q;
    assign bus.dout  = dout_q;

    // Per-consumer occupancy and the worst-case fill that gates upstream.
    always_comb begin
        fill_s = '0;
        for (int k = 0; k < output_size; k++) begin
            occ_s[k] = wp_q - rp_q[k];
            if (occ_s[k] > fill_s) begin
                fill_s = occ_s[k];
            end else begin
                fill_s = fill_s;
            end
        end
        full_s = (fill_s == DEPTH_P);
    end

    // Upstream requester: accept a word on ack unless full, then rest a cycle.
    always_comb begin
        wr_en_s = bus.ack_l & ~full_s;
        wp_d    = wp_q + PW'(wr_en_s);
        if (bus.ack_l) begin
            req_l_d = 1'b0;
        end else if (fill_s < DEPTH_P) begin
            req_l_d = 1'b1;
        end else begin
            req_l_d = 1'b0;
        end
    end

    // Downstream responders: each consumer served independently, ack never twice in a row.
    always_comb begin
        ack_r_d = '0;
        dout_d  = dout_q;
        for (int k = 0; k < output_size; k++) begin
            rp_d[k] = rp_q[k];
            if (bus.req_r[k] && !ack_r_q[k] && (occ_s[k] != '0)) begin
                ack_r_d[k]                           = 1'b1;
                dout_d[data_width*k +: data_width]   = mem_q[rp_q[k][AW-1:0]];
                rp_d[k]                              = rp_q[k] + PW'(1'b1);
`ifdef BROADCAST_RESPONDER_BYPASS_EN
            end else if (wr_en_s && bus.req_r[k] && !ack_r_q[k] && (occ_s[k] == '0)) begin
                // Empty consumer takes the incoming word directly; its read
                // pointer advances in step with the write pointer.
                ack_r_d[k]                           = 1'b1;
                dout_d[data_width*k +: data_width]   = bus.din;
                rp_d[k]                              = rp_q[k] + PW'(1'b1);
`endif
            end else begin
                ack_r_d[k] = 1'b0;
                rp_d[k]    = rp_q[k];
            end
        end
    end

    // Pointer, handshake and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            ack_r_q <= '0;
            dout_q  <= '0;
            req_l_q <= 1'b0;
            for (int k = 0; k < output_size; k++) begin
                rp_q[k] <= '0;
            end
        end else begin
            wp_q    <= wp_d;
            ack_r_q <= ack_r_d;
            dout_q  <= dout_d;
            req_l_q <= req_l_d;
            for (int k = 0; k < output_size; k++) begin
                rp_q[k] <= rp_d[k];
            end
        end
    end

    // Storage array; contents are don't-care after reset so it has none.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wp_q[AW-1:0]] <= bus.din;
        end
    end
endmodule
